evr_tod_event_sequencer: RTL and testbench



---
 rtl/evr_tod_pkg.sv | 29 ++
 rtl/evr_tod_event_sequencer.sv | 129 ++++++++++++
 tb/tb_evr_tod_event_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/evr_tod_pkg.sv
// ============================================================================
// Module      : evr_tod_pkg
// Description : Shared event codes and state encoding for the ToD sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package evr_tod_pkg;

  localparam logic [7:0] TOD_BIT0  = 8'h70;
  localparam logic [7:0] TOD_BIT1  = 8'h71;
  localparam logic [7:0] TOD_LATCH = 8'h7d;
  localparam logic [7:0] EVT_IDLE  = 8'h00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    GAP      = 2'd2,
    WAIT_PPS = 2'd3
  } tod_state_e;

  // Codes owned by the ToD protocol; external senders must not inject them.
  function automatic logic is_reserved(input logic [7:0] code);
    return (code == TOD_BIT0) || (code == TOD_BIT1) || (code == TOD_LATCH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/evr_tod_event_sequencer.sv
// ============================================================================
// Module      : evr_tod_event_sequencer
// Description : Emits the ToD latch event on PPS, then serialises the seconds
//               value MSB-first, sharing the event slot with external traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module evr_tod_event_sequencer
  import evr_tod_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic        Pps,
  input  logic [31:0] SecondsIn,
  input  logic        ExtEventValid,
  input  logic [7:0]  ExtEventCode,
  output logic        ExtEventReady,
  output logic [7:0]  EventStream,
  output logic        Busy,
  output logic [5:0]  BitCount,
  output logic        Overrun,
  output logic        Reject
);

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES);

  tod_state_e  state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  bit_count_q, bit_count_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic [7:0]  event_q, event_d;
  logic        overrun_q, overrun_d;
  logic        reject_q, reject_d;

  logic w_latch;
  logic w_ext_xfer;

  assign w_latch       = Pps && Enable;
  assign ExtEventReady = !w_latch;
  assign w_ext_xfer    = ExtEventValid && ExtEventReady;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_count_d = bit_count_q;
    gap_cnt_d   = gap_cnt_q;
    event_d     = EVT_IDLE;
    overrun_d   = 1'b0;
    reject_d    = 1'b0;

    if (w_latch) begin
      event_d     = TOD_LATCH;
      shreg_d     = SecondsIn;
      bit_count_d = 6'd0;
      state_d     = SEND;
      overrun_d   = (state_q == SEND) || (state_q == GAP);
    end else begin
      if (w_ext_xfer) begin
        event_d  = is_reserved(ExtEventCode) ? EVT_IDLE : ExtEventCode;
        reject_d = is_reserved(ExtEventCode);
      end

      if (!Enable) begin
        state_d = IDLE;
      end else begin
        unique case (state_q)
          SEND: begin
            // An external transfer owns the slot; the pending bit waits.
            if (!w_ext_xfer) begin
              event_d = shreg_q[31] ? TOD_BIT1 : TOD_BIT0;
              shreg_d = {shreg_q[30:0], 1'b0};
              if (bit_count_q >= 6'd31) begin
                bit_count_d = 6'd32;
                state_d     = WAIT_PPS;
              end else begin
                bit_count_d = bit_count_q + 6'd1;
                if (GAP_LOAD != 8'd0) begin
                  gap_cnt_d = GAP_LOAD;
                  state_d   = GAP;
                end
              end
            end
          end
          GAP: begin
            gap_cnt_d = (gap_cnt_q != 8'd0) ? gap_cnt_q - 8'd1 : 8'd0;
            if (gap_cnt_q <= 8'd1) begin
              state_d = SEND;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= IDLE;
      shreg_q     <= 32'd0;
      bit_count_q <= 6'd0;
      gap_cnt_q   <= 8'd0;
      event_q     <= EVT_IDLE;
      overrun_q   <= 1'b0;
      reject_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_count_q <= bit_count_d;
      gap_cnt_q   <= gap_cnt_d;
      event_q     <= event_d;
      overrun_q   <= overrun_d;
      reject_q    <= reject_d;
    end
  end

  assign EventStream = event_q;
  assign Busy        = (state_q == SEND) || (state_q == GAP);
  assign BitCount    = bit_count_q;
  assign Overrun     = overrun_q;
  assign Reject      = reject_q;

endmodule

`default_nettype wire

// File: tb/tb_evr_tod_event_sequencer.sv
// ============================================================================
// Module      : tb_evr_tod_event_sequencer
// Description : Self-checking bench with a cycle-time reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_evr_tod_event_sequencer;

  localparam int GAP = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Enable = 1'b0;
  logic        Pps = 1'b0;
  logic [31:0] SecondsIn = 32'd0;
  logic        ExtEventValid = 1'b0;
  logic [7:0]  ExtEventCode = 8'd0;
  logic        ExtEventReady;
  logic [7:0]  EventStream;
  logic        Busy;
  logic [5:0]  BitCount;
  logic        Overrun;
  logic        Reject;

  evr_tod_event_sequencer #(.GAP_CYCLES(GAP)) dut (
    .Clock(Clock), .Reset(Reset), .Enable(Enable), .Pps(Pps),
    .SecondsIn(SecondsIn), .ExtEventValid(ExtEventValid),
    .ExtEventCode(ExtEventCode), .ExtEventReady(ExtEventReady),
    .EventStream(EventStream), .Busy(Busy), .BitCount(BitCount),
    .Overrun(Overrun), .Reject(Reject)
  );

  always #5 Clock = ~Clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bits become eligible GAP+1 cycles after the previous one.
  logic [31:0] m_sec = 32'd0;
  int          m_sent = 0;
  bit          m_run = 1'b0;
  int          cyc = 0;
  int          m_next = 0;
  logic [7:0]  e_ev = 8'd0;
  bit          e_ovr = 1'b0;
  bit          e_rej = 1'b0;
  bit          model_valid = 1'b0;

  always @(posedge Clock) begin
    bit latch, xfer, rsv;
    cyc++;
    check("ready", ExtEventReady, !(Pps && Enable));
    latch = Pps && Enable;
    xfer  = ExtEventValid && !latch;
    rsv   = (ExtEventCode == 8'h70) || (ExtEventCode == 8'h71) || (ExtEventCode == 8'h7d);
    if (Reset) begin
      e_ev = 8'd0; e_ovr = 1'b0; e_rej = 1'b0;
      m_run = 1'b0; m_sent = 0; m_sec = 32'd0;
    end else if (latch) begin
      e_ev   = 8'h7d;
      e_ovr  = m_run && (m_sent < 32);
      e_rej  = 1'b0;
      m_sec  = SecondsIn;
      m_sent = 0;
      m_run  = 1'b1;
      m_next = cyc + 1;
    end else begin
      e_ev = 8'd0; e_ovr = 1'b0; e_rej = 1'b0;
      if (xfer) begin
        e_ev  = rsv ? 8'd0 : ExtEventCode;
        e_rej = rsv;
      end
      if (!Enable) begin
        m_run = 1'b0;
      end else if (m_run && m_sent < 32 && cyc >= m_next && !xfer) begin
        e_ev   = m_sec[31 - m_sent] ? 8'h71 : 8'h70;
        m_sent = m_sent + 1;
        m_next = cyc + 1 + GAP;
      end
    end
    model_valid = 1'b1;
  end

  always @(negedge Clock) begin
    if (model_valid) begin
      check("event", EventStream, e_ev);
      check("busy", Busy, m_run && (m_sent < 32));
      check("bitcount", BitCount, m_sent);
      check("overrun", Overrun, e_ovr);
      check("reject", Reject, e_rej);
    end
  end

  logic [7:0] seen[$];
  int         ovr_count = 0;

  always @(negedge Clock) begin
    if (EventStream != 8'd0) seen.push_back(EventStream);
    if (Overrun) ovr_count++;
  end

  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic pps_pulse(input logic [31:0] sec);
    Pps = 1'b1; SecondsIn = sec;
    step();
    Pps = 1'b0;
  endtask

  initial begin
    logic [7:0] a5_bits[8];
    int bc0, n28;
    bit found, last_ready;
    int next_pps;
    a5_bits = '{8'h71, 8'h70, 8'h71, 8'h70, 8'h70, 8'h71, 8'h70, 8'h71};

    repeat (3) step();
    check("rst_event", EventStream, 8'h00);
    check("rst_bitcount", BitCount, 6'd0);
    check("rst_busy", Busy, 1'b0);
    check("rst_overrun", Overrun, 1'b0);
    Reset = 1'b0;
    Enable = 1'b1;
    step();

    // Nominal sequence with literal expectations
    seen.delete();
    ovr_count = 0;
    pps_pulse(32'hA500_0001);
    check("t1_latch", EventStream, 8'h7d);
    step();
    check("t1_bit31", EventStream, 8'h71);
    for (int i = 0; i < GAP; i++) begin
      step();
      check("t1_gap", EventStream, 8'h00);
    end
    step();
    check("t1_bit30", EventStream, 8'h70);
    repeat (200) step();
    check("t1_count", seen.size(), 33);
    for (int i = 0; i < 8; i++) check("t1_msb_bits", seen[i + 1], a5_bits[i]);
    check("t1_last", seen[32], 8'h71);
    check("t1_bitcount", BitCount, 6'd32);
    check("t1_busy", Busy, 1'b0);
    check("t1_overrun", ovr_count, 0);

    // External traffic stalls the bit stream
    pps_pulse($urandom);
    repeat (12) step();
    bc0 = BitCount;
    seen.delete();
    ExtEventValid = 1'b1; ExtEventCode = 8'h28;
    repeat (20) step();
    ExtEventValid = 1'b0;
    n28 = 0;
    foreach (seen[i]) if (seen[i] == 8'h28) n28++;
    check("t2_ext_count", n28, 20);
    check("t2_only_ext", seen.size(), 20);
    check("t2_frozen", BitCount, bc0);
    repeat (200) step();
    check("t2_complete", BitCount, 6'd32);

    // Latch and external request in the same cycle
    Pps = 1'b1; SecondsIn = 32'h1234_5678;
    ExtEventValid = 1'b1; ExtEventCode = 8'h28;
    #1 check("t3_ready_low", ExtEventReady, 1'b0);
    step();
    check("t3_latch", EventStream, 8'h7d);
    Pps = 1'b0;
    #1 check("t3_ready_high", ExtEventReady, 1'b1);
    step();
    check("t3_ext", EventStream, 8'h28);
    ExtEventValid = 1'b0;

    // Early PPS restarts the sequence
    found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      if (BitCount == 6'd10) found = 1'b1;
      else step();
    end
    check("t4_reach10", found, 1'b1);
    seen.delete();
    pps_pulse(32'h0000_0002);
    check("t4_overrun", Overrun, 1'b1);
    check("t4_latch", EventStream, 8'h7d);
    step();
    check("t4_overrun_once", Overrun, 1'b0);
    repeat (200) step();
    check("t4_count", seen.size(), 33);
    check("t4_bit1", seen[31], 8'h71);
    check("t4_bit0", seen[32], 8'h70);

    // Reserved external code
    pps_pulse($urandom);
    repeat (7) step();
    bc0 = BitCount;
    ExtEventValid = 1'b1; ExtEventCode = 8'h7d;
    #1 check("t5_ready", ExtEventReady, 1'b1);
    step();
    ExtEventValid = 1'b0;
    check("t5_idle", EventStream, 8'h00);
    check("t5_reject", Reject, 1'b1);
    check("t5_bitcount", BitCount, bc0);
    check("t5_busy", Busy, 1'b1);
    step();
    check("t5_reject_once", Reject, 1'b0);

    // Reset in GAP, then full restart
    bc0 = BitCount;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (BitCount != bc0[5:0]) found = 1'b1;
      else step();
    end
    check("t6_reach_gap", found, 1'b1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("t6_event", EventStream, 8'h00);
    check("t6_bitcount", BitCount, 6'd0);
    check("t6_busy", Busy, 1'b0);
    seen.delete();
    pps_pulse($urandom);
    repeat (200) step();
    check("t6_restart", seen.size(), 33);
    check("t6_bitcount_full", BitCount, 6'd32);

    // Enable dropped mid-sequence
    pps_pulse($urandom);
    repeat (7) step();
    Enable = 1'b0;
    seen.delete();
    repeat (30) step();
    check("t6_no_bits", seen.size(), 0);
    check("t6_idle_busy", Busy, 1'b0);
    Enable = 1'b1;

    // Randomized traffic against the model
    next_pps = 20;
    last_ready = 1'b1;
    for (int c = 0; c < 6000; c++) begin
      Pps = 1'b0;
      Reset = ($urandom_range(0, 999) < 2);
      if (c == next_pps) begin
        Pps = 1'b1;
        SecondsIn = $urandom;
        next_pps = c + $urandom_range(60, 260);
      end
      if ($urandom_range(0, 99) == 0) Enable = !Enable;
      if (!(ExtEventValid && !last_ready)) begin
        ExtEventValid = ($urandom_range(0, 9) == 0);
        case ($urandom_range(0, 7))
          0: ExtEventCode = 8'h70;
          1: ExtEventCode = 8'h71;
          2: ExtEventCode = 8'h7d;
          default: ExtEventCode = 8'($urandom_range(1, 255));
        endcase
      end
      #1 last_ready = ExtEventReady;
      step();
    end
    Reset = 1'b0; Pps = 1'b0; ExtEventValid = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
